// File: rtl/uart_onchip_memory2_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Grants are combinational; read data returns through a 2-stage (valid, id) pipeline.
module uart_onchip_memory2_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic              req0, req1;
    logic              gnt0, gnt1;
    logic              rd_issue;
    logic              ptr_q, ptr_d;
    logic              vld_p0_q, id_p0_q;
    logic              m0_rdv_q, m1_rdv_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // ptr_q = 0 gives m0 priority on a collision, 1 gives m1 priority
    always_comb begin
        gnt0 = req0 & (~req1 | ~ptr_q);
        gnt1 = req1 & (~req0 |  ptr_q);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    // A simultaneous read+write is a write only and never enters the read pipeline
    assign rd_issue = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);

    always_comb begin
        m0_waitrequest = req0 & ~gnt0;
        m1_waitrequest = req1 & ~gnt1;
        mem_chipselect = gnt0 | gnt1;
        mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
        mem_address    = gnt1 ? m1_address   : m0_address;
        mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
        mem_byteenable = {BE_W{1'b1}};
        if (gnt0 && m0_write) begin
            mem_byteenable = m0_byteenable;
        end else if (gnt1 && m1_write) begin
            mem_byteenable = m1_byteenable;
        end
    end

    assign mem_clken = reset_n;

    // Stage p0: read accepted, RAM q available next cycle; stage p1: q captured, strobe out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= 1'b0;
            vld_p0_q   <= 1'b0;
            id_p0_q    <= 1'b0;
            m0_rdv_q   <= 1'b0;
            m1_rdv_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_p0_q <= rd_issue;
            id_p0_q  <= gnt1;
            m0_rdv_q <= vld_p0_q & ~id_p0_q;
            m1_rdv_q <= vld_p0_q &  id_p0_q;
            if (vld_p0_q && !id_p0_q) begin
                m0_rdata_q <= mem_readdata;
            end
            if (vld_p0_q && id_p0_q) begin
                m1_rdata_q <= mem_readdata;
            end
        end
    end

    assign m0_readdata      = m0_rdata_q;
    assign m1_readdata      = m1_rdata_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;

endmodule

// File: tb/tb_uart_onchip_memory2_arbiter.sv
// Bench for the two-master RAM arbiter: vector table for grants and mem_* drive,
// a RAM model behind the arbiter, and a read-return scoreboard.
module tb_uart_onchip_memory2_arbiter;

    typedef struct {
        bit          r0, w0;
        logic [9:0]  a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        bit          r1, w1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        int          g;     // expected grant: 0 none, 1 m0, 2 m1
    } vec_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;

    logic [31:0] ram [1024];
    logic [31:0] ref_mem [1024];
    sb_t         sb_q [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl [12];

    uart_onchip_memory2_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with registered q
    initial for (int i = 0; i < 1024; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic pop_ret(input bit id);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk(id ? "unexpected_m1_rdv" : "unexpected_m0_rdv", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ret_id", {31'd0, id}, {31'd0, e.id});
            chk("ret_latency", cyc, e.cyc + 2);
            chk(id ? "m1_readdata" : "m0_readdata", id ? m1_readdata : m0_readdata, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (m0_readdatavalid) pop_ret(1'b0);
            if (m1_readdatavalid) pop_ret(1'b1);
        end
    end

    function automatic vec_t mkv(bit r0, bit w0, logic [9:0] a0, logic [3:0] be0, logic [31:0] d0,
                                 bit r1, bit w1, logic [9:0] a1, logic [3:0] be1, logic [31:0] d1,
                                 int g);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.g = g;
        return v;
    endfunction

    // Entered at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1
    task automatic run_vec(input vec_t v, input bit push);
        logic [9:0]  ga;
        logic [3:0]  gbe;
        logic [31:0] gd;
        bit          gr, gw;
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
        @(negedge clk);
        chk("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, (v.r0 | v.w0) && v.g != 1});
        chk("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, (v.r1 | v.w1) && v.g != 2});
        chk("mem_chipselect", {31'd0, mem_chipselect}, {31'd0, v.g != 0});
        if (v.g != 0) begin
            ga  = (v.g == 1) ? v.a0 : v.a1;
            gbe = (v.g == 1) ? v.be0 : v.be1;
            gd  = (v.g == 1) ? v.d0 : v.d1;
            gr  = (v.g == 1) ? v.r0 : v.r1;
            gw  = (v.g == 1) ? v.w0 : v.w1;
            chk("mem_write", {31'd0, mem_write}, {31'd0, gw});
            chk("mem_address", {22'd0, mem_address}, {22'd0, ga});
            chk("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, gw ? gbe : 4'hF});
            if (gw) begin
                chk("mem_writedata", mem_writedata, gd);
                for (int b = 0; b < 4; b++)
                    if (gbe[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
            end else if (gr && push) begin
                sb_q.push_back('{id: (v.g == 2), data: ref_mem[ga], cyc: cyc});
            end
        end else begin
            chk("mem_write_idle", {31'd0, mem_write}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_vec(mkv(0,0,0,0,0, 0,0,0,0,0, 0), 1'b1);
    endtask

    initial begin
        // Arbitration/write/read vectors; pointer starts at m0 after reset
        tbl[0]  = mkv(0,1,10'h005,4'hF,32'hDEADBEEF, 0,0,10'h000,4'h0,32'h0,        1);
        tbl[1]  = mkv(1,0,10'h005,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1);
        tbl[2]  = mkv(0,0,10'h000,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        0);
        tbl[3]  = mkv(0,0,10'h000,4'h0,32'h0,        0,1,10'h3FF,4'hF,32'h11223344, 2);
        tbl[4]  = mkv(0,0,10'h000,4'h0,32'h0,        0,1,10'h3FF,4'h8,32'hAA000000, 2);
        tbl[5]  = mkv(1,0,10'h3FF,4'h3,32'h0,        1,0,10'h005,4'h1,32'h0,        1);
        tbl[6]  = mkv(0,1,10'h010,4'hF,32'h0000CAFE, 1,0,10'h005,4'h1,32'h0,        2);
        tbl[7]  = mkv(0,1,10'h010,4'hF,32'h0000CAFE, 0,0,10'h000,4'h0,32'h0,        1);
        tbl[8]  = mkv(0,0,10'h000,4'h0,32'h0,        1,1,10'h010,4'hF,32'h12345678, 2);
        tbl[9]  = mkv(1,0,10'h010,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1);
        tbl[10] = mkv(1,0,10'h3FF,4'h0,32'h0,        1,0,10'h010,4'h0,32'h0,        2);
        tbl[11] = mkv(1,0,10'h3FF,4'h0,32'h0,        0,0,10'h000,4'h0,32'h0,        1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
        chk("rst_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
        chk("rst_m0_readdata", m0_readdata, 32'd0);
        chk("rst_m1_readdata", m1_readdata, 32'd0);
        chk("rst_mem_clken", {31'd0, mem_clken}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("mem_clken_run", {31'd0, mem_clken}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b1);
        idle(4);
        chk("m0_readdata_hold", m0_readdata, 32'hAA223344);
        chk("m1_readdata_hold", m1_readdata, 32'h12345678);

        // Reset lands while an m0 read is in flight: that return must vanish
        run_vec(mkv(1,0,10'h005,4'h0,32'h0, 0,0,0,0,0, 1), 1'b0);
        m0_read = 1'b0;
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("inrst_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
            chk("inrst_mem_clken", {31'd0, mem_clken}, 32'd0);
            chk("inrst_m0_readdata", m0_readdata, 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Both masters read continuously from reset: strict alternation starting at m0
        for (int i = 0; i < 6; i++)
            run_vec(mkv(1,0,10'h005,4'h0,32'h0, 1,0,10'h3FF,4'h0,32'h0, (i % 2 == 0) ? 1 : 2), 1'b1);
        idle(3);

        // m1 alone for three grants hands priority to m0 on the next collision
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) run_vec(mkv(0,0,0,0,0, 1,0,10'h010,4'h0,32'h0, 2), 1'b1);
        run_vec(mkv(1,0,10'h005,4'h0,32'h0, 1,0,10'h010,4'h0,32'h0, 1), 1'b1);
        run_vec(mkv(0,0,0,0,0, 1,0,10'h010,4'h0,32'h0, 2), 1'b1);
        idle(4);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_onchip_memory2_arbiter.md
UART_ONCHIP_MEMORY2_ARBITER -- requirements
Module: uart_onchip_memory2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of the shared RAM (1024 x 32).
REQ-002 Parameter DATA_W, default 32: data width; byte-enable width is DATA_W/8.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 Ports m0_address / m1_address, input, ADDR_W: requester word address.
REQ-006 Ports m0_byteenable / m1_byteenable, input, 4: write byte lanes.
REQ-007 Ports m0_read, m0_write / m1_read, m1_write, input, 1 each: request strobes.
REQ-008 Ports m0_writedata / m1_writedata, input, DATA_W: write data.
REQ-009 Ports m0_waitrequest / m1_waitrequest, output, 1: request not accepted this cycle.
REQ-010 Ports m0_readdata / m1_readdata, output, DATA_W: registered read data.
REQ-011 Ports m0_readdatavalid / m1_readdatavalid, output, 1: one-cycle read-return strobe.
REQ-012 Ports mem_address (ADDR_W), mem_byteenable (4), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W), output: drive the single-port RAM.
REQ-013 Port mem_clken, output, 1: RAM clock enable.
REQ-014 Port mem_readdata, input, DATA_W: RAM q, valid one cycle after the address cycle.

Function
REQ-015 Request from mX = mX_read | mX_write; the arbiter SHALL grant at most one requester per cycle, combinationally in the same cycle.
REQ-016 Only one requester active: it SHALL be granted; its waitrequest = 0.
REQ-017 Both active: the requester named by the 1-bit priority pointer SHALL be granted; the other SHALL see waitrequest = 1 and hold its request.
REQ-018 After any grant, the pointer SHALL point to the non-granted requester (round-robin); with no grant it SHALL hold.
REQ-019 waitrequest SHALL be 0 for a requester with no active request.
REQ-020 Granted cycle: mem_chipselect = 1, mem_address/byteenable/writedata = granted requester's, mem_write = granted mX_write.
REQ-021 No grant: mem_chipselect = 0 and mem_write = 0; the remaining mem_* outputs are don't-care.
REQ-022 mX_read and mX_write both high: treated as a write only; no readdatavalid is produced.
REQ-023 Reads SHALL issue with byteenable forced to 4'hF toward memory.
REQ-024 Read pipeline: 2-stage (valid, id) shift register; a read granted in cycle N SHALL yield mX_readdata = mem_readdata sampled at the end of cycle N+1, with mX_readdatavalid = 1 in cycle N+2 only.
REQ-025 Back-to-back reads, including alternating requesters, SHALL each be accepted one per cycle and returned in issue order, one per cycle.
REQ-026 mX_readdata SHALL hold its last value when readdatavalid = 0.
REQ-027 Write latency: the write commits in the grant cycle; a read of the same address granted in cycle N+1 or later SHALL return the new data.
REQ-028 mem_clken SHALL be 1 whenever reset_n = 1.

Reset
REQ-029 reset_n = 0 SHALL asynchronously clear: pointer to m0, pipeline valid bits, readdatavalid = 0, readdata = 0, mem_clken = 0.
REQ-030 Reads in flight at reset SHALL be discarded; no readdatavalid after reset deassertion without a new grant.
REQ-031 Deassertion SHALL be taken synchronously to clk; the first grant is possible on the first edge after release.

Verification
REQ-032 m0 writes 0xDEADBEEF to address 0x005, be = 4'hF; m0 reads 0x005 -> m0_readdatavalid two cycles after the read grant, with m0_readdata = 0xDEADBEEF.
REQ-033 m0 and m1 both read continuously for 6 cycles from reset -> grants m0,m1,m0,m1,m0,m1; each waitrequest alternates; 6 returns in order.
REQ-034 Byte lanes: write 0x11223344 to address 0x3FF, then write 0xAA000000 with be = 4'b1000; read -> 0xAA223344.
REQ-035 m1 issues read+write simultaneously with writedata 0x12345678 to address 0x010 -> no m1_readdatavalid; subsequent read returns 0x12345678.
REQ-036 Assert reset_n = 0 in the cycle after an m0 read grant -> m0_readdatavalid never asserts; pointer = m0; mem_clken = 0 until release.
REQ-037 m1 alone requests for 3 cycles, then m0 and m1 together -> m0 granted first (pointer reached m0 after m1's grants).
